alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single-cycle 32-bit `alu` between two independent requesters (e.g. the execute stage and a multi-cycle helper unit). Each requester presents operands and an `aluc` code over a valid/ready handshake. The arbiter grants one request per cycle round-robin and registers the result and flags into a one-entry output buffer. That buffer drains over a valid/ready response channel tagged with the source requester.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match `alu`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_aluc` / `req1_aluc`  in  4  operation code (`alu` encoding).
- `rsp_valid`  out  1  output buffer holds a result.
- `rsp_ready`  in  1  consumer takes the result this cycle.
- `rsp_src`  out  1  requester that issued the buffered result.
- `rsp_r`  out  WIDTH  result.
- `rsp_zero`, `rsp_carry`, `rsp_negative`, `rsp_overflow`  out  1  flags of that operation.

## Operation
- `aluc` encoding:
  - 0000 ADDU, 0010 ADD, 0001 SUBU, 0011 SUB.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 100x LUI.
  - 1011 SLT, 1010 SLTU.
  - 1100 SRA, 1101 SRL, 111x SLL.
  - For shifts, `a` is the shift amount and `b` is shifted.
- `slot_free` = !rsp_valid || rsp_ready.
- Arbitration state is a 1-bit pointer `prio`, which names the favoured requester.
  - Both requesters valid: grant `prio`.
  - One requester valid: grant it.
- `reqN_ready` = slot_free && grant==N && reqN_valid. The ready outputs are combinational from valid, `prio`, `rsp_valid` and `rsp_ready`.
- On an accepted request, the granted operands are muxed into `alu`.
  - `r` and all four flags are captured into the buffer, with `rsp_src` = N.
  - `prio` becomes !N.
- No grant means `prio` is unchanged.
- Buffer states are EMPTY and FULL.
  - EMPTY → FULL on accept.
  - FULL → EMPTY when `rsp_ready` and no accept.
  - FULL → FULL on `rsp_ready` plus accept: the buffer is overwritten with the new result.
- While FULL and `rsp_ready`=0, all `rsp_*` outputs hold stable and both readies are 0.
- Requesters must hold valid and payload stable until ready.
- Flags pass through from `alu` unmodified. Arithmetic is mod 2^WIDTH.

## Timing
- Latency: request accepted at edge T, so the response is visible after edge T. It is consumable at edge T+1 at the earliest.
- Throughput: 1 op/cycle with `rsp_ready` held high. With both requesters saturating, grants strictly alternate.
- Reset values:
  - `rsp_valid`=0, `rsp_src`=0, `rsp_r`=0, all flags 0.
  - `prio`=0.
  - `req0_ready`=`req1_ready`=0 while `rst_n`=0.
- Reset mid-operation: a buffered result is discarded immediately, asynchronously. The first grant after release follows `prio`=0.
- A requester dropping valid before ready is a protocol violation; its behaviour is undefined and it is flagged by the bench assertion.

## Structure
- Package `alu_pkg` holds:
  - `aluc` localparams: ALU_ADDU … ALU_SLL.
  - A packed flags struct: zero, carry, negative, overflow.
  - The buffer-state encoding.
- One sub-module: the existing `alu`, instantiated once. Arbitration, the mux and the buffer live in `alu_arbiter`.

## Test plan
- Single ADDU:
  - Stimulus: req0 only, aluc 0000, a=ffffffff, b=00000001, rsp_ready=1.
  - Response: next cycle rsp_valid=1, rsp_src=0, r=00000000, zero=1, carry=1.
- Contention:
  - Stimulus: both requesters valid continuously after reset. req0 issues ADD 7fffffff+00000001; req1 issues SUB a=80000000, b=00000001.
  - Response: results alternate src 0,1,0,1. req0 gives r=80000000, overflow=1. req1 gives r=7fffffff, overflow=1.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles while the buffer is FULL.
  - Response: rsp_* stable and both readies 0. After release, the next grant goes to !rsp_src.
- SRA:
  - Stimulus: req1 issues aluc 1100, a=00000010, b=f1234567.
  - Response: r=fffff123, negative=1, rsp_src=1.
- SLT vs SLTU:
  - Stimulus: a=ffffffff, b=7fffffff.
  - Response: aluc 1011 gives r=00000001. aluc 1010 gives r=00000000, zero=1.
- Reset mid-operation:
  - Stimulus: drop `rst_n` while rsp_valid=1.
  - Response: rsp_valid=0 with no clock edge. After release, with both requesters valid, req0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu and the two-requester arbiter around it:
// operation codes, the flags bundle and the output-buffer state encoding.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALUC_W    = 4;

  localparam logic [ALUC_W-1:0] ALU_ADDU = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_SUBU = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 4'b0011;
  localparam logic [ALUC_W-1:0] ALU_AND  = 4'b0100;
  localparam logic [ALUC_W-1:0] ALU_OR   = 4'b0101;
  localparam logic [ALUC_W-1:0] ALU_XOR  = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_NOR  = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_LUI  = 4'b1000;
  localparam logic [ALUC_W-1:0] ALU_SLTU = 4'b1010;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 4'b1011;
  localparam logic [ALUC_W-1:0] ALU_SRA  = 4'b1100;
  localparam logic [ALUC_W-1:0] ALU_SRL  = 4'b1101;
  localparam logic [ALUC_W-1:0] ALU_SLL  = 4'b1110;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } alu_flags_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request and response channels between the two requesters, the consumer
// and alu_arbiter.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
);
  logic              req0_valid;
  logic              req0_ready;
  logic [WIDTH-1:0]  req0_a;
  logic [WIDTH-1:0]  req0_b;
  logic [ALUC_W-1:0] req0_aluc;

  logic              req1_valid;
  logic              req1_ready;
  logic [WIDTH-1:0]  req1_a;
  logic [WIDTH-1:0]  req1_b;
  logic [ALUC_W-1:0] req1_aluc;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_src;
  logic [WIDTH-1:0]  rsp_r;
  logic              rsp_zero;
  logic              rsp_carry;
  logic              rsp_negative;
  logic              rsp_overflow;

  modport master (
    output req0_valid, req0_a, req0_b, req0_aluc,
    output req1_valid, req1_a, req1_b, req1_aluc,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_src, rsp_r, rsp_zero, rsp_carry, rsp_negative, rsp_overflow
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_aluc,
    input  req1_valid, req1_a, req1_b, req1_aluc,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_src, rsp_r, rsp_zero, rsp_carry, rsp_negative, rsp_overflow
  );
endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU. Shifts take the amount from a and shift b;
// carry is the unsigned carry/borrow, overflow is set only by ADD and SUB.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ALUC_W-1:0] aluc,
  output logic [WIDTH-1:0]  r,
  output alu_flags_t        flags
);
  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;
  logic [SH_W-1:0] shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = a[SH_W-1:0];

  always_comb begin
    r     = '0;
    flags = '0;
    case (aluc)
      ALU_ADDU, ALU_ADD: begin
        r           = sum[WIDTH-1:0];
        flags.carry = sum[WIDTH];
      end
      ALU_SUBU, ALU_SUB: begin
        r           = diff[WIDTH-1:0];
        flags.carry = diff[WIDTH];
      end
      ALU_AND:                     r = a & b;
      ALU_OR:                      r = a | b;
      ALU_XOR:                     r = a ^ b;
      ALU_NOR:                     r = ~(a | b);
      ALU_LUI, ALU_LUI | 4'd1:     r = b << (WIDTH / 2);
      ALU_SLT:                     r = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: begin
        r           = WIDTH'(diff[WIDTH]);
        flags.carry = diff[WIDTH];
      end
      ALU_SRA:                     r = WIDTH'($signed(b) >>> shamt);
      ALU_SRL:                     r = b >> shamt;
      ALU_SLL, ALU_SLL | 4'd1:     r = b << shamt;
      default:                     r = '0;
    endcase
    // Signed overflow: operand signs vs result sign
    if (aluc == ALU_ADD) flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    if (aluc == ALU_SUB) flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    flags.zero     = (r == '0);
    flags.negative = r[WIDTH-1];
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu between two requesters, with a one-entry
// registered response buffer tagged by source.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  buf_state_t        state_q, state_d;
  logic              prio_q;
  logic              grant;
  logic              any_valid;
  logic              slot_free;
  logic              accept;
  logic [WIDTH-1:0]  op_a, op_b, alu_r;
  logic [ALUC_W-1:0] op_aluc;
  alu_flags_t        alu_flags;
  logic              rsp_src_q;
  logic [WIDTH-1:0]  rsp_r_q;
  alu_flags_t        rsp_flags_q;

  // Grant prio on contention, otherwise whoever is asking
  assign slot_free = (state_q == BUF_EMPTY) || bus.rsp_ready;
  assign any_valid = bus.req0_valid || bus.req1_valid;
  assign grant     = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
  assign accept    = rst_n && slot_free && any_valid;

  assign bus.req0_ready = accept && !grant && bus.req0_valid;
  assign bus.req1_ready = accept &&  grant && bus.req1_valid;

  assign op_a    = grant ? bus.req1_a    : bus.req0_a;
  assign op_b    = grant ? bus.req1_b    : bus.req0_b;
  assign op_aluc = grant ? bus.req1_aluc : bus.req0_aluc;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a     (op_a),
    .b     (op_b),
    .aluc  (op_aluc),
    .r     (alu_r),
    .flags (alu_flags)
  );

  // Buffer occupancy: a same-cycle drain and accept keeps it FULL
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (accept) state_d = BUF_FULL;
      BUF_FULL:  if (!accept && bus.rsp_ready) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BUF_EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      rsp_src_q   <= 1'b0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
    end else if (accept) begin
      prio_q      <= !grant;
      rsp_src_q   <= grant;
      rsp_r_q     <= alu_r;
      rsp_flags_q <= alu_flags;
    end
  end

  assign bus.rsp_valid    = (state_q == BUF_FULL);
  assign bus.rsp_src      = rsp_src_q;
  assign bus.rsp_r        = rsp_r_q;
  assign bus.rsp_zero     = rsp_flags_q.zero;
  assign bus.rsp_carry    = rsp_flags_q.carry;
  assign bus.rsp_negative = rsp_flags_q.negative;
  assign bus.rsp_overflow = rsp_flags_q.overflow;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed cases plus randomized traffic against a queue-based reference of
// the arbiter and an arithmetic model of the alu operations.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(32)) bus ();
  alu_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  bit m_prio = 1'b0;
  logic [36:0] exp_q[$];
  logic [36:0] rsp_obs;

  assign rsp_obs = {bus.rsp_src, bus.rsp_r, bus.rsp_zero, bus.rsp_carry,
                    bus.rsp_negative, bus.rsp_overflow};

  a_hold0: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.req0_valid && !bus.req0_ready) |=>
      (bus.req0_valid && $stable({bus.req0_aluc, bus.req0_a, bus.req0_b})))
    else $error("FAIL req0 dropped or changed before ready");
  a_hold1: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.req1_valid && !bus.req1_ready) |=>
      (bus.req1_valid && $stable({bus.req1_aluc, bus.req1_a, bus.req1_b})))
    else $error("FAIL req1 dropped or changed before ready");

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {src, r, zero, carry, negative, overflow} from plain arithmetic
  function automatic logic [36:0] ref_op(input logic src, input logic [3:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, us;
    longint sa, sb, ss;
    logic [31:0] r;
    logic c, v;
    int sh;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(a % 32);
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0000, 4'b0010: begin
        us = ua + ub;
        r  = us[31:0];
        c  = us[32];
        if (op == 4'b0010) begin
          ss = sa + sb;
          v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
      end
      4'b0001, 4'b0011: begin
        us = ua - ub;
        r  = us[31:0];
        c  = ua < ub;
        if (op == 4'b0011) begin
          ss = sa - sb;
          v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
      end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1000, 4'b1001: r = {b[15:0], 16'h0000};
      4'b1011: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1010: begin
        r = (ua < ub) ? 32'd1 : 32'd0;
        c = ua < ub;
      end
      4'b1100: begin
        ss = sb >>> sh;
        r  = ss[31:0];
      end
      4'b1101: r = b >> sh;
      default: r = b << sh;
    endcase
    return {src, r, (r == 32'd0), c, r[31], v};
  endfunction

  task automatic set_req(input bit n, input bit v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (!n) begin
      bus.req0_valid = v; bus.req0_aluc = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_aluc = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hffff_ffff;
      2:       return 32'h8000_0000;
      3:       return 32'h7fff_ffff;
      4:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  // One clock: check readies and buffer at negedge, then advance the model
  task automatic step(output bit acc0, output bit acc1);
    bit slot, any, g;
    @(negedge clk);
    slot = (exp_q.size() == 0) || bus.rsp_ready;
    any  = bus.req0_valid || bus.req1_valid;
    g    = (bus.req0_valid && bus.req1_valid) ? m_prio : bus.req1_valid;
    acc0 = slot && any && !g;
    acc1 = slot && any && g;
    check("req0_ready", 64'(bus.req0_ready), 64'(acc0));
    check("req1_ready", 64'(bus.req1_ready), 64'(acc1));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("rsp", 64'(rsp_obs), 64'(exp_q[0]));
    @(posedge clk);
    if (exp_q.size() != 0 && bus.rsp_ready) void'(exp_q.pop_front());
    if (acc0 || acc1) begin
      if (g) exp_q.push_back(ref_op(1'b1, bus.req1_aluc, bus.req1_a, bus.req1_b));
      else   exp_q.push_back(ref_op(1'b0, bus.req0_aluc, bus.req0_a, bus.req0_b));
      m_prio = !g;
    end
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_fields", 64'(rsp_obs), 64'd0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check("rst_readies", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    exp_q.delete();
    m_prio = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit a0, a1;
    logic [36:0] held;
    bus.rsp_ready = 1'b0;
    set_req(0, 0, 4'h0, 32'h0, 32'h0);
    set_req(1, 0, 4'h0, 32'h0, 32'h0);
    do_reset();

    // Single ADDU wrapping to zero
    set_req(0, 1, ALU_ADDU, 32'hffff_ffff, 32'h0000_0001);
    bus.rsp_ready = 1'b1;
    step(a0, a1);
    set_req(0, 0, 4'h0, 32'h0, 32'h0);
    check("addu_valid", 64'(bus.rsp_valid), 64'd1);
    check("addu_src", 64'(bus.rsp_src), 64'd0);
    check("addu_r", 64'(bus.rsp_r), 64'h0);
    check("addu_zc", 64'({bus.rsp_zero, bus.rsp_carry}), 64'd3);
    step(a0, a1);

    // Contention: grants alternate 0,1,0,1
    do_reset();
    set_req(0, 1, ALU_ADD, 32'h7fff_ffff, 32'h0000_0001);
    set_req(1, 1, ALU_SUB, 32'h8000_0000, 32'h0000_0001);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(a0, a1);
      check("cont_src", 64'(bus.rsp_src), 64'(i % 2));
      check("cont_r", 64'(bus.rsp_r), (i % 2 == 1) ? 64'h7fff_ffff : 64'h8000_0000);
      check("cont_ovf", 64'(bus.rsp_overflow), 64'd1);
    end

    // Backpressure while FULL holding a req1 result
    bus.rsp_ready = 1'b0;
    held = {1'b1, 32'h7fff_ffff, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step(a0, a1);
      check("bp_hold", 64'(rsp_obs), 64'(held));
      check("bp_readies", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    step(a0, a1);
    check("bp_next_src", 64'(bus.rsp_src), 64'd0);

    // SRA from req1
    do_reset();
    set_req(1, 1, ALU_SRA, 32'h0000_0010, 32'hf123_4567);
    bus.rsp_ready = 1'b1;
    step(a0, a1);
    set_req(1, 0, 4'h0, 32'h0, 32'h0);
    check("sra_r", 64'(bus.rsp_r), 64'hffff_f123);
    check("sra_neg", 64'(bus.rsp_negative), 64'd1);
    check("sra_src", 64'(bus.rsp_src), 64'd1);

    // SLT vs SLTU on the same operands
    set_req(0, 1, ALU_SLT, 32'hffff_ffff, 32'h7fff_ffff);
    step(a0, a1);
    check("slt_r", 64'(bus.rsp_r), 64'd1);
    set_req(0, 1, ALU_SLTU, 32'hffff_ffff, 32'h7fff_ffff);
    step(a0, a1);
    set_req(0, 0, 4'h0, 32'h0, 32'h0);
    check("sltu_r", 64'(bus.rsp_r), 64'd0);
    check("sltu_zero", 64'(bus.rsp_zero), 64'd1);
    step(a0, a1);

    // Reset while a result is buffered
    set_req(0, 1, ALU_OR, 32'h1234_0000, 32'h0000_5678);
    bus.rsp_ready = 1'b0;
    step(a0, a1);
    set_req(0, 0, 4'h0, 32'h0, 32'h0);
    check("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
    do_reset();
    set_req(0, 1, ALU_XOR, 32'h0f0f_0f0f, 32'hffff_0000);
    set_req(1, 1, ALU_NOR, 32'h0000_0000, 32'h0000_0000);
    bus.rsp_ready = 1'b1;
    step(a0, a1);
    check("post_rst_src", 64'(bus.rsp_src), 64'd0);

    // Random traffic; requests are held until accepted
    for (int i = 0; i < 3000; i++) begin
      if (a0 || !bus.req0_valid) begin
        if ($urandom_range(0, 3) != 0)
          set_req(0, 1, 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
        else
          set_req(0, 0, 4'h0, 32'h0, 32'h0);
      end
      if (a1 || !bus.req1_valid) begin
        if ($urandom_range(0, 3) != 0)
          set_req(1, 1, 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
        else
          set_req(1, 0, 4'h0, 32'h0, 32'h0);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step(a0, a1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
